// File: rtl/cache_lru_param.sv
// True-LRU recency tracker for a set-associative cache.
// Keeps one full MRU..LRU order list per set in block RAM and self-initialises it after reset.
module cache_lru_param #(
   parameter int WAYS     = 4,
   parameter int SET_BITS = 11,
   localparam int IDX_W   = $clog2(WAYS)
) (
   input  logic                main_clk,
   input  logic                main_rst,
   input  logic [SET_BITS-1:0] addr,
   input  logic                enable_write,
   input  logic [IDX_W-1:0]    used_index,
   input  logic                demote,
   output logic [IDX_W-1:0]    least_used_index,
   output logic                init_busy
);

   localparam int SETS = 2 ** SET_BITS;
   localparam int LW   = WAYS * IDX_W;

   // state | meaning
   // INIT  | walking every set, writing the identity order; requests ignored
   // RUN   | normal lookups and updates
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]          r_state;
   logic [SET_BITS-1:0] r_cnt;
   logic [LW-1:0]       r_mem [SETS];
   logic [LW-1:0]       r_rdata;
   logic [SET_BITS-1:0] r_addr;
   logic                r_we;
   logic [IDX_W-1:0]    r_used;
   logic                r_dem;
   logic                r_fwd;
   logic [LW-1:0]       r_fwd_list;
   logic                r_rd_ok;

   logic [LW-1:0]       w_eff;
   logic [LW-1:0]       w_new;
   logic [LW-1:0]       w_ident;
   logic                w_init;
   logic                w_wr_en;
   logic [SET_BITS-1:0] w_wr_addr;
   logic [LW-1:0]       w_wr_data;
   int                  w_pos;

   assign w_init    = (r_state == ST_INIT);
   assign init_busy = w_init;

   // RAM returns old data on a same-set read/write, so the freshest list comes from the bypass.
   assign w_eff            = r_fwd ? r_fwd_list : r_rdata;
   assign least_used_index = r_rd_ok ? w_eff[(WAYS-1)*IDX_W +: IDX_W] : '0;

   always_comb begin
      w_ident = '0;
      for (int i = 0; i < WAYS; i++) begin
         w_ident[i*IDX_W +: IDX_W] = IDX_W'(i);
      end
   end

   always_comb begin
      w_pos = 0;
      for (int i = 0; i < WAYS; i++) begin
         if (w_eff[i*IDX_W +: IDX_W] == r_used) begin
            w_pos = i;
         end
      end
      w_new = w_eff;
      if (!r_dem) begin
         w_new[0 +: IDX_W] = r_used;
         for (int i = 1; i < WAYS; i++) begin
            if (i <= w_pos) begin
               w_new[i*IDX_W +: IDX_W] = w_eff[(i-1)*IDX_W +: IDX_W];
            end
         end
      end else begin
         for (int i = 0; i < WAYS - 1; i++) begin
            if (i >= w_pos) begin
               w_new[i*IDX_W +: IDX_W] = w_eff[(i+1)*IDX_W +: IDX_W];
            end
         end
         w_new[(WAYS-1)*IDX_W +: IDX_W] = r_used;
      end
   end

   assign w_wr_en   = !main_rst && (w_init || r_we);
   assign w_wr_addr = w_init ? r_cnt   : r_addr;
   assign w_wr_data = w_init ? w_ident : w_new;

   always_ff @(posedge main_clk) begin
      if (w_wr_en) begin
         r_mem[w_wr_addr] <= w_wr_data;
      end
      r_rdata <= r_mem[addr];
   end

   always_ff @(posedge main_clk) begin
      r_addr     <= addr;
      r_used     <= used_index;
      r_dem      <= demote;
      r_fwd_list <= w_new;
   end

   always_ff @(posedge main_clk) begin
      if (main_rst) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_fwd   <= 1'b0;
         r_rd_ok <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_cnt   <= r_cnt + SET_BITS'(1);
               r_we    <= 1'b0;
               r_fwd   <= 1'b0;
               r_rd_ok <= 1'b0;
               if (r_cnt == {SET_BITS{1'b1}}) begin
                  r_state <= ST_RUN;
               end
            end
            default: begin
               r_we    <= enable_write;
               r_fwd   <= r_we && (addr == r_addr);
               r_rd_ok <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_lru_param.sv
// Scoreboard bench for cache_lru_param: a 4-way/16-set and an 8-way/8-set instance.
module tb_cache_lru_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst4, we4, dm4, chk4, busy4;
   logic [3:0] a4;
   logic [1:0] u4, lru4;
   logic       rst8, we8, dm8, chk8, busy8;
   logic [2:0] a8, u8, lru8;

   int   q4[$];
   int   q8[$];
   logic rchk4 = 1'b0;
   logic rchk8 = 1'b0;
   int   ncmp  = 0;
   int   nerr  = 0;

   cache_lru_param #(.WAYS(4), .SET_BITS(4)) u_dut4 (
      .main_clk(clk), .main_rst(rst4), .addr(a4), .enable_write(we4),
      .used_index(u4), .demote(dm4), .least_used_index(lru4), .init_busy(busy4));

   cache_lru_param #(.WAYS(8), .SET_BITS(3)) u_dut8 (
      .main_clk(clk), .main_rst(rst8), .addr(a8), .enable_write(we8),
      .used_index(u8), .demote(dm8), .least_used_index(lru8), .init_busy(busy8));

   task automatic check(input string nm, input int act, input int exp);
      ncmp++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      rchk4 <= chk4;
      rchk8 <= chk8;
   end

   always @(negedge clk) begin
      if (rchk4) begin
         if (q4.size() == 0) begin
            ncmp++; nerr++;
            $display("FAIL q4_underflow: got output with no expected entry");
         end else begin
            check("lru4", int'(lru4), q4.pop_front());
         end
      end
      if (rchk8) begin
         if (q8.size() == 0) begin
            ncmp++; nerr++;
            $display("FAIL q8_underflow: got output with no expected entry");
         end else begin
            check("lru8", int'(lru8), q8.pop_front());
         end
      end
   end

   task automatic set_in(input int d, input int a, input int we, input int u, input int dm, input int exp);
      if (d == 0) begin
         a4 = 4'(a); we4 = (we != 0); u4 = 2'(u); dm4 = (dm != 0); chk4 = (exp >= 0);
         if (exp >= 0) q4.push_back(exp);
      end else begin
         a8 = 3'(a); we8 = (we != 0); u8 = 3'(u); dm8 = (dm != 0); chk8 = (exp >= 0);
         if (exp >= 0) q8.push_back(exp);
      end
   endtask

   // exp < 0 means this cycle's output is not checked.
   task automatic acc(input int d, input int a, input int we, input int u, input int dm, input int exp);
      @(posedge clk); #1;
      set_in(d, a, we, u, dm, exp);
   endtask

   task automatic rd(input int d, input int a, input int exp);
      acc(d, a, 0, 0, 0, exp);
   endtask

   task automatic idle(input int d);
      acc(d, 0, 0, 0, 0, -1);
   endtask

   // Reset lands on a write to set wr_a; the same write stays requested through INIT and must be ignored.
   task automatic do_init(input int d, input int wr_a, input int ways, input int sets);
      int n;
      @(posedge clk); #1;
      set_in(d, wr_a, 1, ways - 1, 0, -1);
      if (d == 0) rst4 = 1'b1; else rst8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check(d == 0 ? "rst_busy4" : "rst_busy8", d == 0 ? int'(busy4) : int'(busy8), 1);
      check(d == 0 ? "rst_lru4"  : "rst_lru8",  d == 0 ? int'(lru4)  : int'(lru8),  0);
      @(posedge clk); #1;
      if (d == 0) rst4 = 1'b0; else rst8 = 1'b0;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         if ((d == 0) ? !busy4 : !busy8) break;
         n++;
      end
      set_in(d, 0, 0, 0, 0, -1);
      check(d == 0 ? "init_cycles4" : "init_cycles8", n, sets);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst4 = 1'b1; rst8 = 1'b1;
      set_in(0, 0, 0, 0, 0, -1);
      set_in(1, 0, 0, 0, 0, -1);

      do_init(0, 6, 4, 16);
      for (int s = 0; s < 16; s++) rd(0, s, 3);

      // touch 3,2,1 on set 5
      acc(0, 5, 1, 3, 0, 3);
      acc(0, 5, 1, 2, 0, 2);
      acc(0, 5, 1, 1, 0, 1);
      rd(0, 5, 0);
      acc(0, 5, 1, 0, 0, 0);
      rd(0, 5, 3);

      // back-to-back on set 7 versus spaced-out on set 8
      acc(0, 7, 1, 3, 0, 3);
      acc(0, 7, 1, 2, 0, 2);
      rd(0, 7, 1);
      acc(0, 8, 1, 3, 0, 3);
      idle(0);
      idle(0);
      acc(0, 8, 1, 2, 0, 2);
      idle(0);
      idle(0);
      rd(0, 8, 1);

      // demote on set 2
      acc(0, 2, 1, 0, 0, 3);
      acc(0, 2, 1, 1, 0, 3);
      acc(0, 2, 1, 2, 0, 3);
      acc(0, 2, 1, 3, 0, 3);
      acc(0, 2, 1, 1, 1, 0);
      acc(0, 2, 1, 1, 1, 1);
      acc(0, 2, 1, 3, 0, 1);
      rd(0, 2, 1);

      // interleaved sets 4 and 9
      acc(0, 4, 1, 1, 0, 3);
      acc(0, 9, 1, 2, 0, 3);
      acc(0, 4, 1, 3, 0, 3);
      acc(0, 9, 1, 0, 1, 3);
      acc(0, 4, 1, 2, 0, 2);
      acc(0, 9, 1, 2, 1, 0);
      rd(0, 4, 0);
      rd(0, 9, 2);

      // reset in the middle of traffic
      acc(0, 6, 1, 0, 0, 3);
      do_init(0, 6, 4, 16);
      rd(0, 6, 3);
      rd(0, 5, 3);
      rd(0, 4, 3);
      idle(0);
      idle(0);

      // 8-way instance
      do_init(1, 3, 8, 8);
      for (int s = 0; s < 8; s++) rd(1, s, 7);
      acc(1, 3, 1, 7, 0, 7);
      acc(1, 3, 1, 0, 1, 6);
      rd(1, 3, 0);
      acc(1, 3, 1, 5, 0, 0);
      do_init(1, 3, 8, 8);
      rd(1, 3, 7);
      idle(1);
      idle(1);

      check("q4_drain", q4.size(), 0);
      check("q8_drain", q8.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nerr);
      $finish;
   end

endmodule
